// File: rtl/esp_at_pkg.sv
// esp_at_pkg: shared types and constants for the ESP8266 AT-command sequencer.
// Contents:
//   state_t     - sequencer FSM states
//   CR/LF/NUL   - ASCII control bytes used by the command table and matcher
//   OK_PAT      - "OK\r\n" response pattern (last 4 received bytes)
//   ERR_PAT     - "ERROR" response pattern (last 5 received bytes)
//   DEFAULT_ROM - default 64-byte command table, address 0 in the top byte
package esp_at_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, WAIT_RESP, GAP, DONE, FAIL} state_t;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] NUL = 8'h00;

    localparam logic [31:0] OK_PAT  = {"OK", CR, LF};
    localparam logic [39:0] ERR_PAT = "ERROR";

    localparam int DEF_DEPTH = 64;
    localparam logic [8*DEF_DEPTH-1:0] DEFAULT_ROM = {
        "AT+CIPMUX=1", CR, LF,
        "AT+CIPSERVER=1,8080", CR, LF,
        {(DEF_DEPTH-34){NUL}}
    };

endpackage

// File: rtl/esp_at_if.sv
// esp_at_if: byte handshake bundle between the sequencer and the shared UART.
// Signals:
//   tx_data/tx_valid/tx_ready - valid/ready byte stream to uart_tx
//   rx_data/rx_valid          - one-cycle strobed byte stream from uart_rx
// Modports: master (sequencer side), slave (UART side).
interface esp_at_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
    modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);

endinterface

// File: rtl/at_resp_matcher.sv
// at_resp_matcher: watches the rx byte stream for "OK\r\n" and "ERROR".
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   clr                - clears history and both hit flags (first byte of a command)
//   rx_data, rx_valid  - received byte and its one-cycle strobe
//   ok_hit, err_hit    - sticky hit flags
module at_resp_matcher
    import esp_at_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       ok_hit,
    output logic       err_hit
);

    logic [39:0] sh;
    logic [39:0] sh_n;

    // Match against the history including the byte arriving this cycle.
    assign sh_n = {sh[31:0], rx_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '0;
            ok_hit  <= 1'b0;
            err_hit <= 1'b0;
        end else if (clr) begin
            sh      <= '0;
            ok_hit  <= 1'b0;
            err_hit <= 1'b0;
        end else if (rx_valid) begin
            sh      <= sh_n;
            ok_hit  <= ok_hit | (sh_n[31:0] == OK_PAT);
            err_hit <= err_hit | (sh_n == ERR_PAT);
        end
    end

endmodule

// File: rtl/esp_at_sequencer.sv
// esp_at_sequencer: streams ROM-held AT commands to uart_tx and checks the replies.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - one-cycle pulse, begins the table from address 0 (ignored while busy)
//   bus        - esp_at_if master: tx valid/ready byte stream, rx strobed byte stream
//   busy       - sequence in progress
//   done       - sticky, every command answered with OK
//   fail       - sticky, a command exhausted its retries
//   cmd_idx    - current command index, frozen at the failing command
//   retry_cnt  - retries used on the current command
module esp_at_sequencer
    import esp_at_pkg::*;
#(
    parameter int ROM_DEPTH   = 64,
    parameter int TIMEOUT_CYC = 5_000_000,
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_GAP   = 50_000,
    parameter int IDXW        = 4,
    parameter logic [8*ROM_DEPTH-1:0] ROM_INIT = DEFAULT_ROM
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    esp_at_if.master        bus,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [IDXW-1:0] cmd_idx,
    output logic [1:0]      retry_cnt
);

    localparam int AW = $clog2(ROM_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYC > RETRY_GAP ? TIMEOUT_CYC : RETRY_GAP);

    state_t          state, state_n;
    logic [AW-1:0]   addr, addr_n, cmd_start, cmd_start_n;
    logic [CW-1:0]   timer, timer_n, timer_inc;
    logic [7:0]      rom_q, tx_data_q, tx_data_n;
    logic            tx_valid_q, tx_valid_n;
    logic            busy_n, done_n, fail_n;
    logic [IDXW-1:0] cmd_idx_n;
    logic [1:0]      retry_n;
    logic            clr, ok_hit, err_hit;

    // Address 0 sits in the most significant byte of ROM_INIT.
    always_ff @(posedge clk)
        rom_q <= ROM_INIT[8*(ROM_DEPTH-1-int'(addr)) +: 8];

    at_resp_matcher u_match (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .rx_data  (bus.rx_data),
        .rx_valid (bus.rx_valid),
        .ok_hit   (ok_hit),
        .err_hit  (err_hit)
    );

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign timer_inc    = (timer == '1) ? timer : timer + 1'b1;

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        cmd_start_n = cmd_start;
        timer_n     = timer;
        tx_data_n   = tx_data_q;
        tx_valid_n  = tx_valid_q;
        busy_n      = busy;
        done_n      = done;
        fail_n      = fail;
        cmd_idx_n   = cmd_idx;
        retry_n     = retry_cnt;
        clr         = 1'b0;
        unique case (state)
            IDLE, DONE, FAIL: if (start) begin
                state_n     = FETCH;
                busy_n      = 1'b1;
                done_n      = 1'b0;
                fail_n      = 1'b0;
                cmd_idx_n   = '0;
                retry_n     = '0;
                addr_n      = '0;
                cmd_start_n = '0;
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                clr = (addr == cmd_start);
                if (rom_q == NUL && addr == cmd_start) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    tx_data_n  = rom_q;
                    tx_valid_n = 1'b1;
                    state_n    = SEND;
                end
            end
            SEND: if (bus.tx_ready) begin
                tx_valid_n = 1'b0;
                if (tx_data_q == LF) begin
                    state_n = WAIT_RESP;
                    timer_n = '0;
                end else begin
                    addr_n  = addr + 1'b1;
                    state_n = FETCH;
                end
            end
            WAIT_RESP: begin
                if (ok_hit) begin
                    cmd_idx_n   = cmd_idx + 1'b1;
                    retry_n     = '0;
                    cmd_start_n = addr + 1'b1;
                    addr_n      = addr + 1'b1;
                    state_n     = FETCH;
                end else if (err_hit || timer == CW'(TIMEOUT_CYC - 1)) begin
                    if (retry_cnt < 2'(MAX_RETRY)) begin
                        retry_n = retry_cnt + 2'd1;
                        timer_n = '0;
                        state_n = GAP;
                    end else begin
                        state_n = FAIL;
                        busy_n  = 1'b0;
                        fail_n  = 1'b1;
                    end
                end else begin
                    timer_n = timer_inc;
                end
            end
            GAP: begin
                if (timer == CW'(RETRY_GAP - 1)) begin
                    addr_n  = cmd_start;
                    state_n = FETCH;
                end else begin
                    timer_n = timer_inc;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            cmd_start  <= '0;
            timer      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            cmd_idx    <= '0;
            retry_cnt  <= '0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            cmd_start  <= cmd_start_n;
            timer      <= timer_n;
            tx_data_q  <= tx_data_n;
            tx_valid_q <= tx_valid_n;
            busy       <= busy_n;
            done       <= done_n;
            fail       <= fail_n;
            cmd_idx    <= cmd_idx_n;
            retry_cnt  <= retry_n;
        end
    end

endmodule
